// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO in front of a UART transmitter.
//   Producer side : wr_data/wr_valid/wr_ready (valid/ready handshake).
//   Consumer side : tx_data/tx_data_valid/tx_data_ready; tx_data is a registered,
//                   first-word-fall-through head byte.
//   Storage       : head register + (DEPTH-1)-entry circular RAM, DEPTH bytes total.
//   level         : bytes held including the head register (0..DEPTH).
//   flush         : synchronous clear; rst_n: asynchronous active-low reset.
module uart_tx_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [7:0]  tx_data,
  output logic        tx_data_valid,
  input  logic        tx_data_ready,
  output logic [AW:0] level
);

  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH-2);

  logic [7:0]    mem [0:DEPTH-2];
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_vld_q,  tx_vld_d;
  logic [AW:0]   level_q,   level_d;
  logic [AW-1:0] wr_ptr_q,  wr_ptr_d;
  logic [AW-1:0] rd_ptr_q,  rd_ptr_d;

  logic wr_en, rd_en, out_free, ram_empty, ram_wr;

  // RAM has DEPTH-1 slots, so pointers wrap explicitly rather than by overflow.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + AW'(1);
  endfunction

  assign wr_ready      = (level_q != LVL_FULL);
  assign wr_en         = wr_valid && wr_ready;
  assign rd_en         = tx_vld_q && tx_data_ready;
  // Head register can take a new byte this cycle.
  assign out_free      = !tx_vld_q || rd_en;
  // Everything counted in level sits in the head register.
  assign ram_empty     = (level_q == {{AW{1'b0}}, tx_vld_q});

  assign tx_data       = tx_data_q;
  assign tx_data_valid = tx_vld_q;
  assign level         = level_q;

  always_comb begin
    tx_data_d = tx_data_q;
    tx_vld_d  = tx_vld_q;
    level_d   = level_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ram_wr    = 1'b0;
    if (flush) begin
      tx_vld_d = 1'b0;
      level_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (out_free && !ram_empty) begin
        tx_data_d = mem[rd_ptr_q];
        tx_vld_d  = 1'b1;
        rd_ptr_d  = ptr_inc(rd_ptr_q);
      end else if (out_free && wr_en) begin
        // Bypass the RAM when it is empty: byte is on tx_data next cycle.
        tx_data_d = wr_data;
        tx_vld_d  = 1'b1;
      end else if (rd_en) begin
        tx_vld_d  = 1'b0;
      end
      ram_wr = wr_en && !(out_free && ram_empty);
      if (ram_wr) wr_ptr_d = ptr_inc(wr_ptr_q);
      case ({wr_en, rd_en})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data_q <= 8'h00;
      tx_vld_q  <= 1'b0;
      level_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      tx_data_q <= tx_data_d;
      tx_vld_q  <= tx_vld_d;
      level_q   <= level_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // Storage array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (ram_wr) mem[wr_ptr_q] <= wr_data;
  end

endmodule
